demux1to2_stream: RTL and testbench
===================================

// Module: demux1to2_stream
// PURPOSE
//  k-bit 1-to-2 stream demultiplexer with valid/ready handshakes: each accepted input word is steered by Sel
//  to output port V or port W and held in a per-port 2-entry buffer until that consumer takes it.
//  Sequential counterpart of the combinational mux2to1: splits one stream into two; sits between a producer
//  and two independent consumers in the tutorial datapath.
// PARAMETERS
//  k      8   data width in bits
//  CW     16  width of per-port transfer counters (used only with DEMUX_COUNT_EN)
// PORTS
//  Clock    in   1   single clock; all state updates on rising edge
//  Resetn   in   1   synchronous, active-low reset
//  U        in   k   input data word
//  U_valid  in   1   producer has a word on U
//  Sel      in   1   destination of current word: 0 -> V, 1 -> W; must be stable while U_valid=1
//  U_ready  out  1   block accepts U this cycle
//  V        out  k   port-V data (head of V buffer)
//  V_valid  out  1   V buffer non-empty
//  V_ready  in   1   V consumer takes the word
//  W        out  k   port-W data (head of W buffer)
//  W_valid  out  1   W buffer non-empty
//  W_ready  in   1   W consumer takes the word
//  CntV     out  CW  count of completed V transfers
//  CntW     out  CW  count of completed W transfers
// BEHAVIOUR
//  - Reset (Resetn=0 at rising edge): both buffers emptied, V=W=0, V_valid=W_valid=0, CntV=CntW=0;
//    words buffered mid-operation are discarded; reset takes priority over every other event.
//  - Accept: U_valid && U_ready at an edge writes U into buffer(Sel). U_ready = !full(buffer(Sel));
//    U_ready depends on Sel and buffer state only, never combinationally on V_ready/W_ready.
//  - Output: V_valid && V_ready at an edge pops V buffer (same for W). V/W are registered, 0 when empty.
//  - Latency: word accepted at edge n appears on its port with valid=1 after edge n (1 cycle).
//  - Per-buffer state: EMPTY -> ONE on push; ONE -> FULL on push without pop; ONE -> EMPTY on pop without
//    push; ONE stays ONE on simultaneous push+pop; FULL -> ONE on pop (push blocked since U_ready=0).
//  - FIFO order preserved per port; no ordering relation between V and W streams.
//  - Blocking: a full buffer stalls only words addressed to it; words for the other port still flow.
//  - Full throughput: steady push+pop sustains one word per cycle per port with depth 2.
//  - U_valid=0: U, Sel ignored; buffers only drain.
// CONFIGURATION
//  - DEMUX_COUNT_EN defined: CntV/CntW increment by 1 on each V/W output handshake, wrap 2^CW-1 -> 0.
//  - DEMUX_COUNT_EN undefined: counter logic absent; CntV and CntW tied to 0; ports remain.
// STRUCTURE
//  - Shared package demux_pkg: default k, buffer depth constant (2), occupancy encoding
//    EMPTY/ONE/FULL, counter width default.
//  - Sub-module demux_buf: k-bit 2-entry FIFO with push/pop, full/empty, head output; instantiated twice.
//  - Top: Sel steering, U_ready generation, optional counters.
// TESTING
//  1. Resetn=0 for 2 cycles with U_valid=1 -> V_valid=W_valid=0, V=W=0, CntV=CntW=0, U_ready=1 after release.
//  2. U=3,Sel=0 then U=5,Sel=1, V_ready=W_ready=1 -> V=3 valid 1 cycle after 1st accept, W=5 after 2nd.
//  3. V_ready=0, send 3,7,2 with Sel=0 -> 3,7 accepted, U_ready=0 on 2; raise V_ready -> V=3,7,2 in order.
//  4. V buffer full (V_ready=0), U=9,Sel=1 -> U_ready=1, W=9 delivered while V stalls.
//  5. Steady stream 1..8 alternating Sel, both ready -> one accept per cycle, V=1,3,5,7, W=2,4,6,8;
//     with DEMUX_COUNT_EN CntV=CntW=4, without it both 0.
//  6. Two words held in W, Resetn=0 one cycle -> W_valid=0, W=0, later W traffic starts fresh (no stale data).

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and the occupancy encoding for the 1-to-2 stream demultiplexer.
// Counter logic in the top is enabled by defining DEMUX_COUNT_EN.
package demux_pkg;

    localparam int K_DEF  = 8;
    localparam int CW_DEF = 16;
    localparam int DEPTH  = 2;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/demux_buf.sv
// Two-entry FIFO whose head word sits in its own register, so the port output
// is registered and reads as zero whenever the buffer is empty.
module demux_buf
    import demux_pkg::*;
#(
    parameter int K = K_DEF
) (
    input  logic         clk,
    input  logic         srst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [K-1:0] din_i,
    output logic [K-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    occ_e         occ_q, occ_d;
    logic [K-1:0] head_q, head_d;
    logic [K-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            EMPTY: begin
                if (push_i) begin
                    head_d = din_i;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                // With one word held, a simultaneous push+pop replaces the head directly.
                if (push_i && pop_i) begin
                    head_d = din_i;
                end else if (push_i) begin
                    tail_d = din_i;
                    occ_d  = FULL;
                end else if (pop_i) begin
                    head_d = '0;
                    occ_d  = EMPTY;
                end
            end
            FULL: begin
                if (pop_i) begin
                    head_d = tail_q;
                    tail_d = '0;
                    occ_d  = ONE;
                end
            end
            default: begin
                occ_d  = EMPTY;
                head_d = '0;
                tail_d = '0;
            end
        endcase
    end

    assign head_o  = head_q;
    assign full_o  = (occ_q == FULL);
    assign empty_o = (occ_q == EMPTY);

endmodule

// File: rtl/demux1to2_stream.sv
// Stream demultiplexer: steers each accepted U word by Sel into the V or W buffer.
// Define DEMUX_COUNT_EN to enable the CntV/CntW transfer counters; otherwise they read 0.
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int k  = K_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic [k-1:0]  U,
    input  logic          U_valid,
    input  logic          Sel,
    output logic          U_ready,
    output logic [k-1:0]  V,
    output logic          V_valid,
    input  logic          V_ready,
    output logic [k-1:0]  W,
    output logic          W_valid,
    input  logic          W_ready,
    output logic [CW-1:0] CntV,
    output logic [CW-1:0] CntW
);

    logic full_v, empty_v, full_w, empty_w;
    logic push_v, push_w, pop_v, pop_w;

    // Readiness looks only at the selected buffer, so a full port never blocks the other.
    assign U_ready = Sel ? !full_w : !full_v;
    assign push_v  = U_valid && !Sel && !full_v;
    assign push_w  = U_valid &&  Sel && !full_w;
    assign V_valid = !empty_v;
    assign W_valid = !empty_w;
    assign pop_v   = V_valid && V_ready;
    assign pop_w   = W_valid && W_ready;

    demux_buf #(.K(k)) u_buf_v (
        .clk     (Clock),
        .srst_n  (Resetn),
        .push_i  (push_v),
        .pop_i   (pop_v),
        .din_i   (U),
        .head_o  (V),
        .full_o  (full_v),
        .empty_o (empty_v)
    );

    demux_buf #(.K(k)) u_buf_w (
        .clk     (Clock),
        .srst_n  (Resetn),
        .push_i  (push_w),
        .pop_i   (pop_w),
        .din_i   (U),
        .head_o  (W),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] cnt_v_q, cnt_v_d;
    logic [CW-1:0] cnt_w_q, cnt_w_d;

    always_comb begin
        cnt_v_d = cnt_v_q + CW'(pop_v);
        cnt_w_d = cnt_w_q + CW'(pop_w);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt_v_q <= '0;
            cnt_w_q <= '0;
        end else begin
            cnt_v_q <= cnt_v_d;
            cnt_w_q <= cnt_w_d;
        end
    end

    assign CntV = cnt_v_q;
    assign CntW = cnt_w_q;
`else
    assign CntV = '0;
    assign CntW = '0;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed testbench for demux1to2_stream; expected counter values follow DEMUX_COUNT_EN.
module tb_demux1to2_stream;

    logic        Clock;
    logic        Resetn;
    logic [7:0]  U;
    logic        U_valid;
    logic        Sel;
    logic        U_ready;
    logic [7:0]  V;
    logic        V_valid;
    logic        V_ready;
    logic [7:0]  W;
    logic        W_valid;
    logic        W_ready;
    logic [15:0] CntV;
    logic [15:0] CntW;

    int compared;
    int mismatched;

`ifdef DEMUX_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    demux1to2_stream #(.k(8), .CW(16)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .U       (U),
        .U_valid (U_valid),
        .Sel     (Sel),
        .U_ready (U_ready),
        .V       (V),
        .V_valid (V_valid),
        .V_ready (V_ready),
        .W       (W),
        .W_valid (W_valid),
        .W_ready (W_ready),
        .CntV    (CntV),
        .CntW    (CntW)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [31:0] cexp(input int n);
        return CNT_ON ? 32'(n) : 32'd0;
    endfunction

    initial begin
        compared   = 0;
        mismatched = 0;
        Resetn  = 1'b0;
        U       = 8'hAA;
        U_valid = 1'b1;
        Sel     = 1'b0;
        V_ready = 1'b1;
        W_ready = 1'b1;

        // 1: reset with a valid word presented
        step();
        step();
        check("rst_v_valid", 32'(V_valid), 32'd0);
        check("rst_w_valid", 32'(W_valid), 32'd0);
        check("rst_v", 32'(V), 32'd0);
        check("rst_w", 32'(W), 32'd0);
        check("rst_cntv", 32'(CntV), 32'd0);
        check("rst_cntw", 32'(CntW), 32'd0);
        Resetn  = 1'b1;
        U_valid = 1'b0;
        #1;
        check("rst_u_ready", 32'(U_ready), 32'd1);
        $display("step1 reset done");

        // 2: one word to each port
        U = 8'd3; Sel = 1'b0; U_valid = 1'b1;
        #1;
        check("t2_u_ready", 32'(U_ready), 32'd1);
        step();
        check("t2_v", 32'(V), 32'd3);
        check("t2_v_valid", 32'(V_valid), 32'd1);
        U = 8'd5; Sel = 1'b1;
        step();
        check("t2_v_drained", 32'(V_valid), 32'd0);
        check("t2_w", 32'(W), 32'd5);
        check("t2_w_valid", 32'(W_valid), 32'd1);
        U_valid = 1'b0;
        step();
        check("t2_w_drained", 32'(W_valid), 32'd0);
        $display("step2 V=3 W=5 delivered");

        // 3: fill V with the consumer stalled
        V_ready = 1'b0; U_valid = 1'b1; Sel = 1'b0; U = 8'd3;
        step();
        check("t3_v_head3", 32'(V), 32'd3);
        U = 8'd7;
        #1;
        check("t3_ready_7", 32'(U_ready), 32'd1);
        step();
        U = 8'd2;
        #1;
        check("t3_ready_2", 32'(U_ready), 32'd0);
        step();
        check("t3_v_still3", 32'(V), 32'd3);

        // 4: W traffic flows while V is full
        Sel = 1'b1; U = 8'd9;
        #1;
        check("t4_ready_w", 32'(U_ready), 32'd1);
        step();
        check("t4_w", 32'(W), 32'd9);
        check("t4_w_valid", 32'(W_valid), 32'd1);
        check("t4_v_stalled", 32'(V), 32'd3);
        U_valid = 1'b0;
        step();
        check("t4_w_drained", 32'(W_valid), 32'd0);
        $display("step4 W=9 passed V stall");

        // 3 resumed: release V consumer, word 2 enters once space opens
        Sel = 1'b0; U = 8'd2; U_valid = 1'b1; V_ready = 1'b1;
        #1;
        check("t3_ready_no_comb", 32'(U_ready), 32'd0);
        step();
        check("t3_v7", 32'(V), 32'd7);
        check("t3_ready_after_pop", 32'(U_ready), 32'd1);
        step();
        check("t3_v2", 32'(V), 32'd2);
        U_valid = 1'b0;
        step();
        check("t3_v_empty", 32'(V_valid), 32'd0);
        check("t3_v_zero", 32'(V), 32'd0);
        check("t3_cntv", 32'(CntV), cexp(4));
        check("t3_cntw", 32'(CntW), cexp(2));
        $display("step3 V=3,7,2 in order");

        // 5: steady alternating stream after a fresh reset
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            U = 8'(i); Sel = (i % 2 == 0); U_valid = 1'b1;
            #1;
            check("t5_ready", 32'(U_ready), 32'd1);
            step();
            if (i % 2 == 1) begin
                check("t5_v", 32'(V), 32'(i));
                check("t5_v_valid", 32'(V_valid), 32'd1);
            end else begin
                check("t5_w", 32'(W), 32'(i));
                check("t5_w_valid", 32'(W_valid), 32'd1);
            end
            $display("step5 word %0d", i);
        end
        U_valid = 1'b0;
        step();
        check("t5_cntv", 32'(CntV), cexp(4));
        check("t5_cntw", 32'(CntW), cexp(4));

        // 6: reset discards words held in W
        W_ready = 1'b0; Sel = 1'b1; U_valid = 1'b1; U = 8'h11;
        step();
        U = 8'h22;
        step();
        check("t6_w_head", 32'(W), 32'h11);
        check("t6_full", 32'(U_ready), 32'd0);
        U_valid = 1'b0; Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        #1;
        check("t6_w_valid", 32'(W_valid), 32'd0);
        check("t6_w_zero", 32'(W), 32'd0);
        check("t6_ready", 32'(U_ready), 32'd1);
        check("t6_cntw_rst", 32'(CntW), 32'd0);
        W_ready = 1'b1; U = 8'h33; U_valid = 1'b1;
        step();
        check("t6_w_fresh", 32'(W), 32'h33);
        U_valid = 1'b0;
        step();
        check("t6_w_no_stale", 32'(W_valid), 32'd0);
        check("t6_w_no_stale_data", 32'(W), 32'd0);
        check("t6_cntw", 32'(CntW), cexp(1));
        $display("step6 reset flushed W");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
